// File: rtl/ti_sbox_layer_seq.sv
// Streams NIBBLES shared nibbles through an external two-stage TI S-box; start-to-done NIBBLES+2 cycles.
// No backpressure: start is ignored while busy. Define TI_SBOX_REMASK_EN to refresh inter-stage shares with rnd.
module ti_sbox_layer_seq #(
  parameter int NIBBLES = 16,
  parameter int SHARES  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [4*NIBBLES*SHARES-1:0]   state_in,
  output logic                          busy,
  output logic                          done,
  output logic [4*NIBBLES*SHARES-1:0]   state_out,
  output logic [4*SHARES-1:0]           s1_in,
  input  logic [4*SHARES-1:0]           s1_out,
  output logic [4*SHARES-1:0]           s2_in,
  input  logic [4*SHARES-1:0]           s2_out,
  input  logic [4*(SHARES-1)-1:0]       rnd,
  output logic                          rnd_used
);

  localparam int PW = $clog2(NIBBLES);
  localparam int SW = 4 * NIBBLES;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_t;

  fsm_t                          fsm_q, fsm_d;
  logic [4*NIBBLES*SHARES-1:0]   state_q, state_d;
  logic [4*SHARES-1:0]           mid_q, mid_d;
  logic [PW-1:0]                 mid_idx_q, mid_idx_d;
  logic                          mid_vld_q, mid_vld_d;
  logic [PW-1:0]                 ptr_q, ptr_d;
  logic [3:0]                    rnd_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      mid_q     <= '0;
      mid_idx_q <= '0;
      mid_vld_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      mid_q     <= mid_d;
      mid_idx_q <= mid_idx_d;
      mid_vld_q <= mid_vld_d;
      ptr_q     <= ptr_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    mid_d     = mid_q;
    mid_idx_d = mid_idx_q;
    mid_vld_d = mid_vld_q;
    ptr_d     = ptr_q;
    rnd_acc   = 4'h0;
    s1_in     = '0;
    s2_in     = '0;

    // Write-back of the previous nibble overlaps the read of the next one; indices always differ.
    if (mid_vld_q) begin
      s2_in = mid_q;
      for (int s = 0; s < SHARES; s++) begin
        state_d[s*SW + 4*int'(mid_idx_q) +: 4] = s2_out[4*s +: 4];
      end
    end

    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = state_in;
          ptr_d   = '0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        for (int s = 0; s < SHARES; s++) begin
          s1_in[4*s +: 4] = state_q[s*SW + 4*int'(ptr_q) +: 4];
        end
        mid_d = s1_out;
`ifdef TI_SBOX_REMASK_EN
        // Fresh masks cancel in the share XOR, so the unshared value is unchanged.
        for (int k = 0; k < SHARES-1; k++) begin
          mid_d[4*k +: 4] = mid_d[4*k +: 4] ^ rnd[4*k +: 4];
          rnd_acc         = rnd_acc ^ rnd[4*k +: 4];
        end
        mid_d[4*(SHARES-1) +: 4] = mid_d[4*(SHARES-1) +: 4] ^ rnd_acc;
`endif
        mid_idx_d = ptr_q;
        mid_vld_d = 1'b1;
        if (int'(ptr_q) == NIBBLES-1) begin
          fsm_d = DRAIN;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      DRAIN: begin
        mid_vld_d = 1'b0;
        fsm_d     = DONE;
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

`ifdef TI_SBOX_REMASK_EN
  assign rnd_used = (fsm_q == RUN);
`else
  logic unused_rnd;
  assign unused_rnd = ^{rnd, rnd_acc};
  assign rnd_used   = 1'b0;
`endif

  assign busy      = (fsm_q == RUN) || (fsm_q == DRAIN);
  assign done      = (fsm_q == DONE);
  assign state_out = state_q;

endmodule

// File: tb/tb_ti_sbox_layer_seq.sv
// Directed bench for ti_sbox_layer_seq: identity stage 1, stage 2 = s2_in ^ s2_xor.
module tb_ti_sbox_layer_seq;
  localparam int NIB = 16;
  localparam int SH  = 3;
  localparam int W   = 4*NIB*SH;

  logic           clk = 1'b0;
  logic           rst_n, start;
  logic [W-1:0]   state_in, state_out;
  logic           busy, done, rnd_used;
  logic [11:0]    s1_in, s1_out, s2_in, s2_out, s2_xor;
  logic [7:0]     rnd;
  int             total = 0, bad = 0, cyc = 0;

  ti_sbox_layer_seq #(.NIBBLES(NIB), .SHARES(SH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
    .busy(busy), .done(done), .state_out(state_out),
    .s1_in(s1_in), .s1_out(s1_out), .s2_in(s2_in), .s2_out(s2_out),
    .rnd(rnd), .rnd_used(rnd_used)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign s1_out = s1_in;
  assign s2_out = s2_in ^ s2_xor;

`ifdef TI_SBOX_REMASK_EN
  localparam logic [W-1:0] RM_ALL = {{16{4'hF}}, {16{4'hA}}, {16{4'h5}}};
  localparam logic [11:0]  RM_NIB = 12'hFA5;
  localparam bit           RM_ON  = 1'b1;
`else
  localparam logic [W-1:0] RM_ALL = '0;
  localparam logic [11:0]  RM_NIB = 12'h000;
  localparam bit           RM_ON  = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] sin;
    logic [11:0]  x;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[3];

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [11:0] nib(input logic [W-1:0] s, input int k);
    logic [11:0] r;
    for (int sh = 0; sh < SH; sh++) r[4*sh +: 4] = s[sh*4*NIB + 4*k +: 4];
    return r;
  endfunction

  function automatic logic [3:0] xo(input logic [11:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8];
  endfunction

  // Runs one layer from IDLE; returns at the negedge of the done cycle.
  task automatic run_layer(input logic [W-1:0] sin, input int pulse_at, output int t0, output int dc);
    logic [11:0] e1, e2;
    @(negedge clk);
    state_in = sin;
    start    = 1'b1;
    t0       = cyc;
    dc       = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      e1 = (c <= NIB) ? nib(sin, c-1) : 12'h000;
      e2 = (c >= 2 && c <= NIB+1) ? (nib(sin, c-2) ^ RM_NIB) : 12'h000;
      chk("s1_in", {180'd0, s1_in}, {180'd0, e1});
      chk("s2_in", {180'd0, s2_in}, {180'd0, e2});
      chk("busy", {191'd0, busy}, {191'd0, (c <= NIB+1)});
      chk("rnd_used", {191'd0, rnd_used}, {191'd0, (RM_ON && c <= NIB)});
      if (done) begin
        dc = c;
        break;
      end
    end
    start = 1'b0;
    chk("done_cycle", W'(dc), W'(18));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_state_out"}, state_out, '0);
    chk({nm, "_ctl"}, {167'd0, busy, done, rnd_used, s1_in, s2_in}, '0);
  endtask

  initial begin
    int t0, t1, dc;
    logic [63:0] gx, ex;

    vecs[0] = '{sin: '0, x: 12'h001,
                exp: {64'h0, 64'h0, 64'h1111_1111_1111_1111}};
    vecs[1] = '{sin: {64'h0, 64'h0, 64'hFEDC_BA98_7654_3210}, x: 12'h000,
                exp: {64'h0, 64'h0, 64'hFEDC_BA98_7654_3210}};
    vecs[2] = '{sin: {64'h0123_4567_89AB_CDEF, 64'hAAAA_5555_0F0F_F0F0, 64'hFEDC_BA98_7654_3210},
                x: 12'h3C5,
                exp: {64'h3210_7654_BA98_FEDC, 64'h6666_9999_C3C3_3C3C, 64'hAB89_EFCD_2301_6745}};

    rst_n = 1'b0; start = 1'b0; state_in = '0; rnd = 8'hA5; s2_xor = 12'h000;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_zero("idle");
    end

    // Table of full layers
    for (int v = 0; v < 3; v++) begin
      s2_xor = vecs[v].x;
      run_layer(vecs[v].sin, -1, t0, dc);
      chk("state_out", state_out, vecs[v].exp ^ RM_ALL);
      for (int k = 0; k < NIB; k++) begin
        gx[4*k +: 4] = xo(nib(state_out, k));
        ex[4*k +: 4] = xo(nib(vecs[v].sin, k)) ^ xo(vecs[v].x);
      end
      chk("share_xor", {128'd0, gx}, {128'd0, ex});
      @(negedge clk);
      chk("done_pulse", {191'd0, done}, '0);
      chk("state_held", state_out, vecs[v].exp ^ RM_ALL);
    end

    // Start while busy is ignored; back-to-back start right after done
    s2_xor = vecs[2].x;
    run_layer(vecs[2].sin, 7, t0, dc);
    chk("busy_start_result", state_out, vecs[2].exp ^ RM_ALL);
    s2_xor = vecs[0].x;
    run_layer(vecs[0].sin, -1, t1, dc);
    chk("b2b_done_abs", W'(t1 - t0 + dc), W'(37));
    chk("b2b_result", state_out, vecs[0].exp ^ RM_ALL);

    // Reset in the middle of a layer
    s2_xor = vecs[2].x;
    @(negedge clk);
    state_in = vecs[2].sin;
    start    = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("busy_before_rst", {191'd0, busy}, {191'd0, 1'b1});
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero("mid_rst");
    @(negedge clk);
    chk_zero("post_rst");
    run_layer(vecs[2].sin, -1, t0, dc);
    chk("after_rst_result", state_out, vecs[2].exp ^ RM_ALL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ti_sbox_layer_seq.md
# ti_sbox_layer_seq

Sequencer for one substitution layer of the threshold-implemented 4-bit S-box. It streams the NIBBLES shared nibbles of a cipher state through an external two-stage TI S-box datapath, one nibble per cycle. It holds the inter-stage share register, optionally re-masks it with fresh randomness, and writes results back in place. It sits between the round-state register file and the combinational TI component-function banks.

## Interface
- NIBBLES, 16, number of 4-bit S-box positions per layer (2..64)
- SHARES, 3, number of Boolean shares per nibble (≥3)

- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous reset, active low
- start  input  1  begin a layer; sampled only in IDLE
- state_in  input  4*NIBBLES*SHARES  shared state; share s, nibble i at bits [s*4*NIBBLES+4*i +: 4]
- busy  output  1  high while layer in progress
- done  output  1  one-cycle pulse, layer complete
- state_out  output  4*NIBBLES*SHARES  shared result, same layout; held until next start
- s1_in  output  4*SHARES  current nibble's shares to stage-1 functions; share s at [4*s +: 4]
- s1_out  input  4*SHARES  stage-1 component-function outputs (combinational)
- s2_in  output  4*SHARES  inter-stage register contents to stage-2 functions
- s2_out  input  4*SHARES  stage-2 component-function outputs (combinational)
- rnd  input  4*(SHARES-1)  fresh randomness, consumed when rnd_used=1
- rnd_used  output  1  high in cycles where rnd is absorbed

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1:
  - copy state_in into the internal state register
  - ptr←0
  - go to RUN
- RUN:
  - s1_in = shares of nibble ptr
  - at edge: mid←s1_out (remasked, see Configuration), mid_idx←ptr, mid_vld←1, ptr←ptr+1
  - if ptr==NIBBLES-1, go to DRAIN
- Write-back, any state with mid_vld=1:
  - s2_in = mid
  - at edge: state[mid_idx]←s2_out, share-wise
- DRAIN:
  - final write-back occurs
  - mid_vld←0
  - go to DONE
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE: ignored, no queuing.
- ptr width: clog2(NIBBLES); no wrap, because the FSM leaves RUN at NIBBLES-1.
- Write-back of nibble i never collides with the read of nibble i+1: different indices, so no hazard.
- s1_in and s2_in are 0 whenever not driving a valid nibble. This avoids spurious share glitching into the component functions.
- Reset (any state, including mid-layer):
  - FSM→IDLE
  - state, mid, mid_idx, ptr cleared to 0
  - mid_vld=0
  - Reset values: busy=0, done=0, rnd_used=0, state_out=0, s1_in=0, s2_in=0
  - A partially processed layer is discarded.

## Timing
- Cycle 0: IDLE with start=1 sampled.
- Cycles 1..NIBBLES: RUN, nibble k issued in cycle k+1 and written back at the end of cycle k+2.
- Cycle NIBBLES+1: DRAIN.
- Cycle NIBBLES+2: done=1, and state_out is final.
- Start-to-done latency: NIBBLES+2 cycles (18 at defaults).
- busy: high in cycles 1..NIBBLES+1; low in DONE.
- rnd_used: equals the RUN-state indicator.
- Back-to-back: start is accepted in the cycle after done. Minimum period is NIBBLES+3 cycles.
- state_out is driven directly from the state register and is valid when done=1.

## Configuration
- Macro: TI_SBOX_REMASK_EN.
- Defined:
  - at mid load, share k (k<SHARES-1) ^= rnd[4k +: 4]
  - last share ^= XOR of all rnd nibbles
  - the unshared value is preserved and inter-stage shares are refreshed
- Undefined:
  - mid←s1_out unmodified
  - rnd is ignored and rnd_used is tied to 0
- Port list is identical in both builds.

## Test plan
- Reset and idle:
  - hold rst_n=0 for 3 cycles, then release with start=0 for 5 cycles
  - busy, done, rnd_used, s1_in, s2_in and state_out stay 0
- Basic layer (bench stage 1 = identity, stage 2 = s2_in ^ 12'h001, state_in=0, macro undefined):
  - done at cycle 18
  - state_out share0 = 64'h1111_1111_1111_1111, shares 1 and 2 = 0
- Ordering (stage 1 = identity, stage 2 = identity, state_in share0 = 64'hFEDC_BA98_7654_3210):
  - s1_in share0 sequence in cycles 1..16 is 0x0..0xF
  - state_out equals state_in
- Remask (TI_SBOX_REMASK_EN defined, identity stages, rnd=8'hA5 constant):
  - every nibble: share0 ^= 5, share1 ^= A, share2 ^= F
  - XOR of the three shares equals the input for all 16 nibbles
- Start while busy:
  - pulse start again at cycle 7
  - done still occurs only at cycle 18; no restart
  - a new start at cycle 19 yields done at cycle 37
- Reset mid-operation:
  - assert rst_n=0 at cycle 9 for one cycle
  - all outputs 0 next cycle
  - a subsequent start completes a full layer with correct results
